// File: rtl/reset_seq_gen.sv
// Reset generator / sequencer for the dclk domain.
// Holds all domain resets for a minimum width, then releases them one by one
// (domain 0 first) with a fixed spacing. Software and watchdog requests restart
// the sequence for unmasked domains. The last reset cause is reported.
module reset_seq_gen #(
  parameter int unsigned NUM_RST  = 4,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned STEP_CYC = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               dclk,
  input  logic               arst_n,
  input  logic               scan_mode,
  input  logic               sw_rst_req,
  input  logic               wdt_rst_req,
  input  logic [NUM_RST-1:0] rst_mask,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               rst_busy,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);

  localparam int unsigned SLOT_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [NUM_RST-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic [1:0]         cause_q, cause_d;

  // State and output registers; arst_n forces the power-on reset state.
  always_ff @(posedge dclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      slot_q  <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Next-state: hold counting, staggered release, and request override.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    rst_n_d = rst_n_q;
    done_d  = 1'b0;
    cause_d = cause_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d    = ST_RELEASE;
          cnt_d      = '0;
          slot_d     = '0;
          rst_n_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
          cnt_d = '0;
          if (slot_q == SLOT_W'(NUM_RST - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
            // Every slot consumes its time; masked domains are simply already high.
            for (int unsigned i = 0; i < NUM_RST; i++) begin
              if (SLOT_W'(i) == slot_d) rst_n_d[i] = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A request wins over everything, including a completion on the same edge.
    if (sw_rst_req || wdt_rst_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      slot_d  = '0;
      rst_n_d = rst_n_q & rst_mask;
      done_d  = 1'b0;
      cause_d = wdt_rst_req ? 2'b10 : 2'b01;
    end
  end

  assign rst_n_o   = scan_mode ? {NUM_RST{arst_n}} : rst_n_q;
  assign rst_busy  = (state_q != ST_IDLE);
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: doc/reset_seq_gen.md
Name: reset_seq_gen

Overview:
- Reset generator and sequencer in the dclk domain. It is the source side of the per-domain reset synchronisers.
- Takes the chip async reset plus software and watchdog reset requests. Produces NUM_RST active-low domain resets with a guaranteed minimum assertion width and staggered, ordered release (domain 0 first).
- Reports busy, completion and last reset cause to the system register block.

Parameters:
- NUM_RST, 4: number of reset outputs / domains; must be >= 1.
- HOLD_CYC, 16: minimum assertion length in dclk cycles; must be >= 1.
- STEP_CYC, 8: dclk cycles between successive domain releases; must be >= 1.
- CNT_W, 8: counter width; 2**CNT_W must exceed max(HOLD_CYC, STEP_CYC).

Ports:
- dclk, input, 1: destination clock; all logic is on its posedge.
- arst_n, input, 1: asynchronous active-low reset (power-on / pad).
- scan_mode, input, 1: DFT bypass.
- sw_rst_req, input, 1: software reset request, dclk-synchronous, level-sampled.
- wdt_rst_req, input, 1: watchdog reset request, dclk-synchronous, level-sampled.
- rst_mask, input, NUM_RST: 1 excludes that domain from soft/watchdog resets; sampled at acceptance.
- rst_n_o, output, NUM_RST: per-domain active-low resets, registered.
- rst_busy, output, 1: high while any sequence is in progress.
- rst_done, output, 1: one-cycle pulse at sequence completion.
- rst_cause, output, 2: cause of the last sequence. 00 = POR, 01 = SW, 10 = WDT.

Behaviour:
- Reset is asynchronous, active-low on arst_n, clock dclk; all flops use async clear or set on arst_n.
- While arst_n = 0:
  - rst_n_o = all 0, rst_busy = 1, rst_done = 0, rst_cause = 00.
  - FSM = HOLD, counter = 0, slot index = 0.
- FSM states:
  - HOLD: counter increments each cycle. When counter = HOLD_CYC-1, go to RELEASE with slot = 0 and counter cleared.
  - RELEASE: on entry to slot k, rst_n_o[k] is set to 1. If it is already 1 (masked), it is unchanged. The counter counts STEP_CYC cycles per slot, then slot increments. After slot NUM_RST-1 has completed STEP_CYC cycles, go to IDLE.
  - IDLE: rst_busy = 0. Accepts requests.
- POR timing, with edge 1 being the first posedge with arst_n = 1:
  - rst_n_o[k] rises after edge HOLD_CYC + k*STEP_CYC.
  - rst_busy falls and rst_done pulses high for one cycle after edge HOLD_CYC + NUM_RST*STEP_CYC.
  - With defaults: releases at 16/24/32/40, done at 48.
- POR ignores rst_mask; all domains are reset.
- Request acceptance:
  - A request sampled high at edge T is accepted in any state, including HOLD and RELEASE.
  - After edge T, every domain with rst_mask = 0 is driven 0. Domains already low stay low. Masked domains that are high stay high.
  - FSM goes to HOLD with counter 0, rst_busy = 1, and release timing restarts from T.
- Priority and cause:
  - If wdt_rst_req and sw_rst_req are both high at the same edge, rst_cause = 10.
  - Otherwise rst_cause = 01 for SW and 10 for WDT.
  - rst_cause updates at acceptance and holds until the next acceptance or arst_n.
- Level requests: a request held high re-triggers every cycle, so the sequence stays in HOLD. Release starts HOLD_CYC cycles after the last high sample.
- Restart mid-sequence: release restarts from slot 0. Each slot's timing is always consumed, whether or not the domain is masked, so timing is deterministic.
- rst_done is never asserted during or after an aborted sequence. It is asserted only at the normal end of RELEASE.
- Scan mode: when scan_mode = 1, every rst_n_o = arst_n through a combinational bypass mux after the register. The FSM keeps running. rst_busy and rst_done are not bypassed.
- Outputs are glitch-free: rst_n_o comes from flops, with only the scan mux after them.

Test Plan:
1. POR, defaults: release arst_n, no requests.
   - Expect rst_n_o 0000 -> 0001 after edge 16, 0011 at 24, 0111 at 32, 1111 at 40.
   - Expect rst_busy 1 -> 0 and a single rst_done pulse at 48; rst_cause = 00.
2. SW reset, rst_mask = 4'b0100: sw_rst_req pulsed 1 cycle in IDLE at edge T.
   - After T, rst_n_o = 0100.
   - Bit 0 rises at T+16, bit 1 at T+24, bit 3 at T+40; bit 2 stays 1 throughout.
   - Done at T+48; rst_cause = 01.
3. Simultaneous sw_rst_req + wdt_rst_req in IDLE -> rst_cause = 10, full unmasked sequence as in 2.
4. WDT request at T+26 during the SW sequence of 2.
   - Domains 0 and 1 go back to 0 after T+26; no rst_done at T+48.
   - Releases occur at T+42, T+50, T+66; rst_done at T+74.
5. arst_n asserted mid-RELEASE:
   - Immediately rst_n_o = 0000, rst_busy = 1, rst_cause = 00.
   - After deassertion, the POR timing of 1 repeats exactly.
6. scan_mode = 1 while toggling arst_n during a sequence -> rst_n_o follows arst_n on all bits; with scan_mode = 0, registered values resume.
